// File: rtl/cpu_pkg.sv
// Shared core constants: instruction encodings used by fetch and decode stages.
package cpu_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [INSTR_W-1:0]    NOP_INSTR = 32'hD503201F;
    localparam logic [10:0]           STUR_OP   = 11'b11111000000;
    localparam logic [7:0]            CBZ_OP    = 8'b10110100;
    localparam logic [REG_ADDR_W-1:0] XZR       = 5'd31;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-stage bus: instruction memory, hazard/branch controls and IF/ID outputs.
interface if_id_stage_if
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = 64
);
    logic                  stall;
    logic                  br_taken;
    logic [PC_W-1:0]       br_target;
    logic [INSTR_W-1:0]    imem_instr;
    logic [PC_W-1:0]       imem_addr;
    logic [PC_W-1:0]       if_id_pc;
    logic [INSTR_W-1:0]    if_id_instr;
    logic                  if_id_valid;
    logic [REG_ADDR_W-1:0] if_id_rs1;
    logic [REG_ADDR_W-1:0] if_id_rs2;

    modport master (
        input  stall, br_taken, br_target, imem_instr,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid, if_id_rs1, if_id_rs2
    );

    modport slave (
        output stall, br_taken, br_target, imem_instr,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid, if_id_rs1, if_id_rs2
    );
endinterface

// File: rtl/reg_field_decode.sv
// Source-register extraction (Reg2Loc-aware); a bubble reads XZR on both ports.
module reg_field_decode
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  valid,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2
);
    logic unused_bits;
    assign unused_bits = ^instr[15:10];

    always_comb begin
        rs1 = instr[9:5];
        rs2 = instr[20:16];
        // Stores and CBZ carry their second source in the Rt field
        if ((instr[31:21] == STUR_OP) || (instr[31:24] == CBZ_OP)) begin
            rs2 = instr[4:0];
        end
        if (!valid) begin
            rs1 = XZR;
            rs2 = XZR;
        end
    end
endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID register: PC ownership, stall hold, branch flush.
// Optional perf counters enabled by defining IF_STAGE_PERF_EN.
module if_id_stage
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    if_id_stage_if.master     bus
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    if_id_pc_q, if_id_pc_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic               if_id_valid_q, if_id_valid_d;

    // Flush outranks stall: the branch is older than the stalled load-use pair
    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (bus.br_taken) begin
            pc_d          = bus.br_target;
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d          = pc_q + PC_W'(4);
            if_id_pc_d    = pc_q;
            if_id_instr_d = bus.imem_instr;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_pc    = if_id_pc_q;
    assign bus.if_id_instr = if_id_instr_q;
    assign bus.if_id_valid = if_id_valid_q;

    reg_field_decode u_decode (
        .instr (if_id_instr_q),
        .valid (if_id_valid_q),
        .rs1   (bus.if_id_rs1),
        .rs2   (bus.if_id_rs2)
    );

`ifdef IF_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters; only reset clears them
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.stall && !bus.br_taken && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (bus.br_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed cycles push expected state, a monitor checks it.
module tb_if_id_stage;
    import cpu_pkg::*;

    localparam logic [31:0] I_ADD  = 32'h8B030041; // ADD X1,X2,X3
    localparam logic [31:0] I_STUR = 32'hF80000C5; // STUR X5,[X6]
    localparam logic [31:0] I_CBZ  = 32'hB4000207; // CBZ X7,+0x40
    localparam logic [31:0] I_LDUR = 32'hF8400149; // LDUR X9,[X10]
    localparam logic [31:0] I_SUB  = 32'hCB0600A4; // SUB X4,X5,X6

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_id_stage_if #(.PC_W(64)) bus ();

`ifdef IF_STAGE_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    if_id_stage #(.PC_W(64), .RESET_PC(64'h0), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef IF_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents one new registered state
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("imem_addr",   bus.imem_addr,   e.addr);
                chk("if_id_pc",    bus.if_id_pc,    e.pc);
                chk("if_id_instr", 64'(bus.if_id_instr), 64'(e.instr));
                chk("if_id_valid", 64'(bus.if_id_valid), 64'(e.v));
                chk("if_id_rs1",   64'(bus.if_id_rs1),   64'(e.rs1));
                chk("if_id_rs2",   64'(bus.if_id_rs2),   64'(e.rs2));
`ifdef IF_STAGE_PERF_EN
                chk("stall_cnt",   64'(stall_cnt), 64'(e.sc));
                chk("flush_cnt",   64'(flush_cnt), 64'(e.fc));
`endif
            end
        end
    end

    task automatic step(input logic rst, input logic stl, input logic br,
                        input logic [63:0] tgt, input logic [31:0] ins,
                        input logic [63:0] e_addr, input logic [63:0] e_pc,
                        input logic [31:0] e_instr, input logic e_v,
                        input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                        input logic [31:0] e_sc, input logic [31:0] e_fc);
        exp_t e;
        @(negedge clk);
        reset          = rst;
        bus.stall      = stl;
        bus.br_taken   = br;
        bus.br_target  = tgt;
        bus.imem_instr = ins;
        e.addr = e_addr; e.pc = e_pc; e.instr = e_instr; e.v = e_v;
        e.rs1 = e_rs1; e.rs2 = e_rs2; e.sc = e_sc; e.fc = e_fc;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; bus.stall = 1'b0; bus.br_taken = 1'b0;
        bus.br_target = '0; bus.imem_instr = '0;
        //    rst  stl  br   target                  instr    | addr       if_id_pc     instr      v  rs1 rs2 sc fc
        step(1, 0, 0, 64'h0,                  I_SUB,  64'h0,     64'h0,       NOP_INSTR, 0, 31, 31, 0, 0);
        // free-running fetch
        step(0, 0, 0, 64'h0,                  I_ADD,  64'h4,     64'h0,       I_ADD,     1,  2,  3, 0, 0);
        step(0, 0, 0, 64'h0,                  I_STUR, 64'h8,     64'h4,       I_STUR,    1,  6,  5, 0, 0);
        step(0, 0, 0, 64'h0,                  I_CBZ,  64'hC,     64'h8,       I_CBZ,     1, 16,  7, 0, 0);
        step(0, 0, 0, 64'h0,                  I_LDUR, 64'h10,    64'hC,       I_LDUR,    1, 10,  0, 0, 0);
        // load-use stall: two held cycles then resume
        step(0, 1, 0, 64'h0,                  I_SUB,  64'h10,    64'hC,       I_LDUR,    1, 10,  0, 1, 0);
        step(0, 1, 0, 64'h0,                  I_SUB,  64'h10,    64'hC,       I_LDUR,    1, 10,  0, 2, 0);
        step(0, 0, 0, 64'h0,                  I_SUB,  64'h14,    64'h10,      I_SUB,     1,  5,  6, 2, 0);
        // taken branch then target fetch
        step(0, 0, 1, 64'h100,                I_ADD,  64'h100,   64'h0,       NOP_INSTR, 0, 31, 31, 2, 1);
        step(0, 0, 0, 64'h0,                  I_STUR, 64'h104,   64'h100,     I_STUR,    1,  6,  5, 2, 1);
        // branch together with stall: flush wins, stall not counted
        step(0, 1, 1, 64'h200,                I_ADD,  64'h200,   64'h0,       NOP_INSTR, 0, 31, 31, 2, 2);
        step(0, 0, 0, 64'h0,                  I_CBZ,  64'h204,   64'h200,     I_CBZ,     1, 16,  7, 2, 2);
        // reach pc=0x40, stall, then reset mid-stall
        step(0, 0, 1, 64'h40,                 I_ADD,  64'h40,    64'h0,       NOP_INSTR, 0, 31, 31, 2, 3);
        step(0, 1, 0, 64'h0,                  I_ADD,  64'h40,    64'h0,       NOP_INSTR, 0, 31, 31, 3, 3);
        step(1, 1, 0, 64'h0,                  I_ADD,  64'h0,     64'h0,       NOP_INSTR, 0, 31, 31, 0, 0);
        step(0, 0, 0, 64'h0,                  I_SUB,  64'h4,     64'h0,       I_SUB,     1,  5,  6, 0, 0);
        // PC wrap at the top of the address space
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, I_ADD, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, NOP_INSTR, 0, 31, 31, 0, 1);
        step(0, 0, 0, 64'h0,                  I_STUR, 64'h0,     64'hFFFF_FFFF_FFFF_FFFC, I_STUR, 1, 6, 5, 0, 1);
        // misaligned target loaded as given
        step(0, 0, 1, 64'h103,                I_ADD,  64'h103,   64'h0,       NOP_INSTR, 0, 31, 31, 0, 2);
        step(0, 0, 0, 64'h0,                  I_ADD,  64'h107,   64'h103,     I_ADD,     1,  2,  3, 0, 2);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
